// File: rtl/sensor_scan_controller_pkg.sv
// Shared constants and state encoding for the sensor scan controller slice.
package sensor_scan_controller_pkg;

    localparam int unsigned SCAN_NUM_CH      = 4;
    localparam int unsigned SCAN_CH_W        = 2;
    localparam int unsigned SCAN_DATA_WIDTH  = 16;
    localparam int unsigned SCAN_ACK_TIMEOUT = 16;
    localparam int unsigned SCAN_FAULT_LIMIT = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StGap  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sensor_scan_controller_if.sv
// Acquisition handshake between the scan controller (master) and the sensor front end (slave).
interface sensor_scan_controller_if
    import sensor_scan_controller_pkg::*;
#(
    parameter int unsigned CH_W       = SCAN_CH_W,
    parameter int unsigned DATA_WIDTH = SCAN_DATA_WIDTH
);

    logic                  acq_req;
    logic [CH_W-1:0]       acq_ch;
    logic                  acq_ack;
    logic [DATA_WIDTH-1:0] acq_data;
    logic                  acq_fault;

    modport master (
        output acq_req,
        output acq_ch,
        input  acq_ack,
        input  acq_data,
        input  acq_fault
    );

    modport slave (
        input  acq_req,
        input  acq_ch,
        output acq_ack,
        output acq_data,
        output acq_fault
    );

endinterface

// File: rtl/sensor_scan_controller_chan_health_counter.sv
// Per-channel consecutive-failure counter with saturating count and sticky fault flag.
module sensor_scan_controller_chan_health_counter #(
    parameter int unsigned FAULT_LIMIT = 3,
    parameter int unsigned CNT_W       = $clog2(FAULT_LIMIT + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bad_pulse,
    input  logic i_good_pulse,
    input  logic i_clear,
    output logic o_fault
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_fault;

    assign w_cnt_inc = (r_cnt >= CNT_W'(FAULT_LIMIT)) ? CNT_W'(FAULT_LIMIT) : r_cnt + 1'b1;

    // A bad transaction reaching the limit overrides a same-edge clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else if (i_bad_pulse) begin
            r_cnt   <= w_cnt_inc;
            r_fault <= (w_cnt_inc == CNT_W'(FAULT_LIMIT)) | (r_fault & ~i_clear);
        end else begin
            if (i_good_pulse || i_clear) begin
                r_cnt <= '0;
            end
            if (i_clear) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign o_fault = r_fault;

endmodule

// File: rtl/sensor_scan_controller.sv
// Walks unmasked sensor channels through one shared acquisition path per scan tick,
// forwarding good samples and tracking per-channel health.
module sensor_scan_controller
    import sensor_scan_controller_pkg::*;
#(
    parameter int unsigned NUM_CH      = SCAN_NUM_CH,
    parameter int unsigned CH_W        = SCAN_CH_W,
    parameter int unsigned DATA_WIDTH  = SCAN_DATA_WIDTH,
    parameter int unsigned ACK_TIMEOUT = SCAN_ACK_TIMEOUT,
    parameter int unsigned FAULT_LIMIT = SCAN_FAULT_LIMIT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_scan_tick,
    input  logic [NUM_CH-1:0]      i_ch_mask,
    input  logic [NUM_CH-1:0]      i_fault_clear,
    sensor_scan_controller_if.master acq_if,
    output logic                   o_out_valid,
    output logic [CH_W-1:0]        o_out_ch,
    output logic [DATA_WIDTH-1:0]  o_out_data,
    output logic [NUM_CH-1:0]      o_ch_fault,
    output logic                   o_safe_req,
    output logic                   o_scan_busy,
    output logic                   o_scan_done,
    output logic                   o_overrun
);

    localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned CNT_W  = $clog2(FAULT_LIMIT + 1);

    scan_state_e           r_state;
    logic [NUM_CH-1:0]     r_mask_l;
    logic [CH_W-1:0]       r_ch;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_acq_req;
    logic                  r_out_valid;
    logic [CH_W-1:0]       r_out_ch;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_safe_req;
    logic                  r_scan_busy;
    logic                  r_scan_done;
    logic                  r_overrun;

    logic                  w_nxt_found;
    logic [CH_W-1:0]       w_nxt_ch;
    logic                  w_timeout;
    logic [NUM_CH-1:0]     w_good;
    logic [NUM_CH-1:0]     w_bad;
    logic [NUM_CH-1:0]     w_ch_fault;

    // Lowest eligible channel: from the live mask when starting, above r_ch mid-scan.
    always_comb begin
        w_nxt_found = 1'b0;
        w_nxt_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((r_state == StIdle) ? !i_ch_mask[i] : (!r_mask_l[i] && (i > int'(r_ch)))) begin
                w_nxt_found = 1'b1;
                w_nxt_ch    = i[CH_W-1:0];
            end
        end
    end

    assign w_timeout = (r_state == StReq) && !acq_if.acq_ack
                       && (r_wait == WAIT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        w_good = '0;
        w_bad  = '0;
        if (r_state == StReq) begin
            if (acq_if.acq_ack) begin
                if (acq_if.acq_fault) begin
                    w_bad[r_ch] = 1'b1;
                end else begin
                    w_good[r_ch] = 1'b1;
                end
            end else if (w_timeout) begin
                w_bad[r_ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_mask_l    <= '0;
            r_ch        <= '0;
            r_wait      <= '0;
            r_acq_req   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_safe_req  <= 1'b0;
            r_scan_busy <= 1'b0;
            r_scan_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_scan_done <= 1'b0;
            r_overrun   <= i_scan_tick && r_scan_busy;
            r_safe_req  <= |(w_ch_fault & ~i_ch_mask);
            unique case (r_state)
                StIdle: begin
                    if (i_enable && i_scan_tick) begin
                        r_mask_l <= i_ch_mask;
                        if (w_nxt_found) begin
                            r_ch        <= w_nxt_ch;
                            r_wait      <= '0;
                            r_acq_req   <= 1'b1;
                            r_scan_busy <= 1'b1;
                            r_state     <= StReq;
                        end else begin
                            r_scan_done <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (acq_if.acq_ack) begin
                        r_acq_req <= 1'b0;
                        r_state   <= StGap;
                        if (!acq_if.acq_fault) begin
                            r_out_valid <= 1'b1;
                            r_out_ch    <= r_ch;
                            r_out_data  <= acq_if.acq_data;
                        end
                    end else if (w_timeout) begin
                        r_acq_req <= 1'b0;
                        r_state   <= StGap;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StGap: begin
                    // Disabling mid-scan abandons the rest of the scan without a done pulse.
                    if (!i_enable) begin
                        r_scan_busy <= 1'b0;
                        r_state     <= StIdle;
                    end else if (w_nxt_found) begin
                        r_ch      <= w_nxt_ch;
                        r_wait    <= '0;
                        r_acq_req <= 1'b1;
                        r_state   <= StReq;
                    end else begin
                        r_scan_done <= 1'b1;
                        r_scan_busy <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sensor_scan_controller_chan_health_counter #(
            .FAULT_LIMIT (FAULT_LIMIT),
            .CNT_W       (CNT_W)
        ) u_health (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_bad_pulse  (w_bad[g]),
            .i_good_pulse (w_good[g]),
            .i_clear      (i_fault_clear[g]),
            .o_fault      (w_ch_fault[g])
        );
    end

    assign acq_if.acq_req = r_acq_req;
    assign acq_if.acq_ch  = r_ch;
    assign o_out_valid    = r_out_valid;
    assign o_out_ch       = r_out_ch;
    assign o_out_data     = r_out_data;
    assign o_ch_fault     = w_ch_fault;
    assign o_safe_req     = r_safe_req;
    assign o_scan_busy    = r_scan_busy;
    assign o_scan_done    = r_scan_done;
    assign o_overrun      = r_overrun;

endmodule
